// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/exec/writeback sequencer for the
// 15-puzzle solver core. Owns the PC, the instruction register and the
// retired-instruction counter, and gates decoder write strobes to EXEC.
//
// Optional build macro: CPU_SEQ_STEP_EN adds a `step` input and a PAUSE
// state after every writeback for single-step debug.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | ROM read strobe asserted, address = pc
// DECODE | latch ROM word into ir, detect HALT opcode
// EXEC   | decoder strobes (reg_we, flag_we) enabled for one cycle
// WB     | commit branch target or pc+1, count the retired instruction
// PAUSE  | (step build only) hold until step
// HALT   | run finished, done high, waiting for start
module cpu_seq_ctrl #(
  parameter logic [8:0] RESET_PC = 9'd0,
  parameter logic [4:0] HALT_OP  = 5'h1F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [22:0] imem_rdata,
  input  logic        dec_pc_we,
  input  logic [8:0]  dec_pc_in,
  input  logic        dec_reg_we,
`ifdef CPU_SEQ_STEP_EN
  input  logic        step,
`endif
  output logic [8:0]  pc,
  output logic        imem_re,
  output logic [22:0] ir,
  output logic        reg_we,
  output logic        flag_we,
  output logic        busy,
  output logic        done,
  output logic [15:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
`ifdef CPU_SEQ_STEP_EN
    S_PAUSE  = 3'd5,
`endif
    S_HALT   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_pc;
  logic [22:0] r_ir;
  logic [15:0] r_instret;
  logic        w_idle_or_halt;
  logic        w_accept;

  assign w_idle_or_halt = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_accept       = w_idle_or_halt && start;

  // State register; reset aborts any run straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start outside IDLE/HALT is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (imem_rdata[22:18] == HALT_OP) w_state_nxt = S_HALT;
        else                              w_state_nxt = S_EXEC;
      end
      S_EXEC:   w_state_nxt = S_WB;
`ifdef CPU_SEQ_STEP_EN
      S_WB:     w_state_nxt = S_PAUSE;
      S_PAUSE: begin
        if (step) w_state_nxt = S_FETCH;
      end
`else
      S_WB:     w_state_nxt = S_FETCH;
`endif
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // PC, instruction register and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= 23'd0;
      r_instret <= 16'd0;
    end else if (w_accept) begin
      r_pc      <= RESET_PC;
      r_instret <= 16'd0;
    end else begin
      case (r_state)
        S_DECODE: r_ir <= imem_rdata;
        S_WB: begin
          // Branch decision sampled in WB: ir and the flag are stable since EXEC.
          if (dec_pc_we) r_pc <= dec_pc_in;
          else           r_pc <= r_pc + 9'd1;
          if (r_instret != 16'hFFFF) r_instret <= r_instret + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign pc      = r_pc;
  assign ir      = r_ir;
  assign instret = r_instret;
  assign imem_re = (r_state == S_FETCH);
  assign reg_we  = (r_state == S_EXEC) && dec_reg_we;
  assign flag_we = (r_state == S_EXEC);
  assign busy    = !w_idle_or_halt;
  assign done    = (r_state == S_HALT);

endmodule
